sba_dbg_master: RTL and testbench

Debug initiator for the external SBA bus: it turns a byte-stream command protocol, typically fed by a UART receive/transmit byte path, into single 32-bit bus transactions. It drives the same address, strobe, write-enable and data signals that peripherals such as cfg, led, uart and spi respond to, and it returns read data or a status byte on the outgoing byte stream. It lets a host peek and poke peripheral registers without the CPU.

---
 rtl/sba_dbg_master.sv | 191 +++++++++++++++++++
 tb/tb_sba_dbg_master.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sba_dbg_master.sv
// rtl/sba_dbg_master.sv - byte-stream command decoder driving single SBA bus transactions
module sba_dbg_master #(
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_dat,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_dat,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [15:0] o_addr,
  output logic        o_stb,
  output logic [3:0]  o_we,
  output logic [31:0] o_dat_w,
  input  logic        i_ack,
  input  logic [31:0] i_dat_r,
  output logic        o_busy
);

  // TIMEOUT=0 still needs a one-bit counter so the declarations stay legal.
  localparam int              CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0]   TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_RESP
  } state_t;

  state_t        state, state_d;
  logic          is_wr, is_wr_d;
  // Byte index while collecting ADDR/DATA; bytes still to send after the current one in RESP.
  logic [1:0]    cnt, cnt_d;
  logic [CW-1:0] to_cnt, to_cnt_d;
  // Remaining read-data bytes queued behind o_tx_dat, next byte in the top slot.
  logic [23:0]   resp_sr, resp_sr_d;

  logic [7:0]    tx_dat_d;
  logic          tx_valid_d;
  logic [15:0]   addr_d;
  logic          stb_d;
  logic [3:0]    we_d;
  logic [31:0]   dat_w_d;
  logic          busy_d;

  // State and every output register; reset drops strobe and response immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      is_wr      <= 1'b0;
      cnt        <= 2'd0;
      to_cnt     <= '0;
      resp_sr    <= 24'h0;
      o_tx_dat   <= 8'h00;
      o_tx_valid <= 1'b0;
      o_addr     <= 16'h0;
      o_stb      <= 1'b0;
      o_we       <= 4'h0;
      o_dat_w    <= 32'h0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_d;
      is_wr      <= is_wr_d;
      cnt        <= cnt_d;
      to_cnt     <= to_cnt_d;
      resp_sr    <= resp_sr_d;
      o_tx_dat   <= tx_dat_d;
      o_tx_valid <= tx_valid_d;
      o_addr     <= addr_d;
      o_stb      <= stb_d;
      o_we       <= we_d;
      o_dat_w    <= dat_w_d;
      o_busy     <= busy_d;
    end
  end

  // Next-state and next-output decode; all registers hold unless a case below moves them.
  always_comb begin
    state_d    = state;
    is_wr_d    = is_wr;
    cnt_d      = cnt;
    to_cnt_d   = to_cnt;
    resp_sr_d  = resp_sr;
    tx_dat_d   = o_tx_dat;
    tx_valid_d = o_tx_valid;
    addr_d     = o_addr;
    stb_d      = o_stb;
    we_d       = o_we;
    dat_w_d    = o_dat_w;

    case (state)
      S_IDLE: begin
        if (i_rx_valid && (i_rx_dat == CMD_RD || i_rx_dat == CMD_WR)) begin
          is_wr_d = (i_rx_dat == CMD_WR);
          cnt_d   = 2'd0;
          state_d = S_ADDR;
        end
      end

      S_ADDR: begin
        if (i_rx_valid) begin
          addr_d = {o_addr[7:0], i_rx_dat};
          if (cnt == 2'd1) begin
            cnt_d = 2'd0;
            if (is_wr) begin
              state_d = S_DATA;
            end else begin
              state_d  = S_BUS;
              stb_d    = 1'b1;
              we_d     = 4'h0;
              to_cnt_d = '0;
            end
          end else begin
            cnt_d = cnt + 2'd1;
          end
        end
      end

      S_DATA: begin
        if (i_rx_valid) begin
          dat_w_d = {o_dat_w[23:0], i_rx_dat};
          if (cnt == 2'd3) begin
            cnt_d    = 2'd0;
            state_d  = S_BUS;
            stb_d    = 1'b1;
            we_d     = 4'hF;
            to_cnt_d = '0;
          end else begin
            cnt_d = cnt + 2'd1;
          end
        end
      end

      S_BUS: begin
        // An ack on the last permitted cycle still wins over the timeout.
        if (i_ack) begin
          stb_d      = 1'b0;
          we_d       = 4'h0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          if (is_wr) begin
            tx_dat_d = RSP_OK;
            cnt_d    = 2'd0;
          end else begin
            tx_dat_d  = i_dat_r[31:24];
            resp_sr_d = i_dat_r[23:0];
            cnt_d     = 2'd3;
          end
        end else if (TO_EN && to_cnt == TO_LAST) begin
          stb_d      = 1'b0;
          we_d       = 4'h0;
          state_d    = S_RESP;
          tx_valid_d = 1'b1;
          tx_dat_d   = RSP_ERR;
          cnt_d      = 2'd0;
        end else begin
          to_cnt_d = to_cnt + CW'(1);
        end
      end

      S_RESP: begin
        if (o_tx_valid && i_tx_ready) begin
          if (cnt == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tx_dat_d  = resp_sr[23:16];
            resp_sr_d = {resp_sr[15:0], 8'h00};
            cnt_d     = cnt - 2'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_sba_dbg_master.sv
// tb/tb_sba_dbg_master.sv - scoreboard bench for sba_dbg_master against a memory-level model
module tb_sba_dbg_master;

  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_rx_dat;
  logic        i_rx_valid;
  logic [7:0]  o_tx_dat;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [15:0] o_addr;
  logic        o_stb;
  logic [3:0]  o_we;
  logic [31:0] o_dat_w;
  logic        i_ack;
  logic [31:0] i_dat_r;
  logic        o_busy;

  always #5 i_clk = ~i_clk;

  sba_dbg_master #(.TIMEOUT(TO)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx_dat   (i_rx_dat),
    .i_rx_valid (i_rx_valid),
    .o_tx_dat   (o_tx_dat),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_addr     (o_addr),
    .o_stb      (o_stb),
    .o_we       (o_we),
    .o_dat_w    (o_dat_w),
    .i_ack      (i_ack),
    .i_dat_r    (i_dat_r),
    .o_busy     (o_busy)
  );

  int checks = 0;
  int errors = 0;

  int ack_delay  = 1;
  bit no_ack     = 1'b0;
  int ready_mode = 0;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] dat;
    bit          wr;
    int          width;
  } bus_t;

  logic [7:0]  tx_q[$];
  bus_t        bus_q[$];
  logic [31:0] model_mem [logic [15:0]];

  // Slave side: small storage indexed by the address nibbles the bench uses.
  logic [31:0] slave_mem [256];
  bit          mem_ready = 1'b0;
  int          stb_cnt = 0;

  function automatic logic [7:0] hidx(logic [15:0] a);
    return {a[15:12], a[3:0]};
  endfunction

  function automatic logic [31:0] dval(logic [15:0] a);
    return {a, ~a};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred that should not", name);
  endtask

  assign i_ack = o_stb && !no_ack && (stb_cnt == ack_delay - 1);

  always @(posedge i_clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) slave_mem[i] <= dval({i[7:4], 8'h00, i[3:0]});
      slave_mem[8'h14] <= 32'h1234_5678;
      mem_ready <= 1'b1;
    end else if (o_stb && i_ack && o_we == 4'hF) begin
      slave_mem[hidx(o_addr)] <= o_dat_w;
    end
    stb_cnt <= o_stb ? stb_cnt + 1 : 0;
  end

  initial begin
    i_dat_r = 32'h0;
    forever begin
      @(negedge i_clk);
      i_dat_r = slave_mem[hidx(o_addr)];
    end
  end

  initial begin
    int p;
    p = 0;
    i_tx_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
        0:       i_tx_ready = 1'b1;
        1:       i_tx_ready = (p % 3 == 0);
        default: i_tx_ready = ($urandom % 2 == 1);
      endcase
      p++;
    end
  end

  // Monitor: bus transactions and response bytes popped from the scoreboard queues.
  initial begin
    bit          prev_stb;
    int          width;
    bit          stall;
    logic [7:0]  stall_dat;
    prev_stb = 1'b0;
    width    = 0;
    stall    = 1'b0;
    stall_dat = 8'h00;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        if (o_stb) begin
          if (!prev_stb) width = 0;
          width++;
          if (bus_q.size() == 0) begin
            fail_now("bus_unexpected");
          end else begin
            check("bus_addr", o_addr, bus_q[0].addr);
            check("bus_we", o_we, bus_q[0].we);
            if (bus_q[0].wr) check("bus_dat_w", o_dat_w, bus_q[0].dat);
          end
        end else if (prev_stb) begin
          if (bus_q.size() > 0) begin
            check("stb_width", width, bus_q[0].width);
            void'(bus_q.pop_front());
          end
          check("tx_valid_after_stb", o_tx_valid, 1);
        end
        prev_stb = o_stb;

        if (stall) begin
          check("tx_hold_valid", o_tx_valid, 1);
          check("tx_hold_dat", o_tx_dat, stall_dat);
        end
        stall     = o_tx_valid && !i_tx_ready;
        stall_dat = o_tx_dat;

        if (o_tx_valid && i_tx_ready) begin
          if (tx_q.size() == 0) fail_now("tx_unexpected");
          else check("tx_byte", o_tx_dat, tx_q.pop_front());
        end
      end else begin
        prev_stb = 1'b0;
        stall    = 1'b0;
      end
    end
  end

  task automatic send_byte(logic [7:0] b);
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b1;
    i_rx_dat   = b;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(bit inject);
    int n;
    n = 0;
    while (o_busy && n < 500) begin
      i_rx_valid = inject && ($urandom % 2 == 1);
      i_rx_dat   = 8'($urandom);
      @(posedge i_clk);
      #1;
      n++;
    end
    i_rx_valid = 1'b0;
    if (o_busy) begin
      fail_now("idle_timeout");
    end else begin
      check("tx_all_sent", tx_q.size(), 0);
      check("bus_all_done", bus_q.size(), 0);
      check("idle_tx_valid", o_tx_valid, 0);
      check("idle_we", o_we, 0);
    end
    tx_q.delete();
    bus_q.delete();
  endtask

  task automatic do_txn(bit wr, logic [15:0] a, logic [31:0] d, int dly, bit na, bit inject);
    bus_t        t;
    logic [31:0] v;
    ack_delay = dly;
    no_ack    = na;
    t.addr  = a;
    t.we    = wr ? 4'hF : 4'h0;
    t.dat   = d;
    t.wr    = wr;
    t.width = na ? TO : dly;
    bus_q.push_back(t);
    if (na) begin
      tx_q.push_back(8'h45);
    end else if (wr) begin
      model_mem[a] = d;
      tx_q.push_back(8'h4B);
    end else begin
      v = model_mem.exists(a) ? model_mem[a] : dval(a);
      tx_q.push_back(v[31:24]);
      tx_q.push_back(v[23:16]);
      tx_q.push_back(v[15:8]);
      tx_q.push_back(v[7:0]);
    end
    send_byte(wr ? 8'h57 : 8'h52);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    if (wr) begin
      send_byte(d[31:24]);
      send_byte(d[23:16]);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
    end
    check("stb_rise", o_stb, 1);
    wait_idle(inject);
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #1;
    check("reset_outputs", {o_stb, o_we, o_addr, o_dat_w, o_tx_valid, o_tx_dat, o_busy}, 0);
    tx_q.delete();
    bus_q.delete();
    no_ack = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    bus_t t;
    i_rst_n    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_dat   = 8'h00;
    model_mem[16'h1004] = 32'h1234_5678;

    repeat (3) @(posedge i_clk);
    #1;
    check("reset_state", {o_stb, o_we, o_addr, o_dat_w, o_tx_valid, o_tx_dat, o_busy}, 0);
    i_rst_n = 1'b1;

    ready_mode = 0;
    do_txn(1'b0, 16'h1004, 32'h0, 1, 1'b0, 1'b0);
    do_txn(1'b1, 16'h3000, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
    do_txn(1'b0, 16'h3000, 32'h0, 2, 1'b0, 1'b0);

    ready_mode = 1;
    do_txn(1'b0, 16'h1004, 32'h0, 5, 1'b0, 1'b0);
    do_txn(1'b1, 16'h7002, 32'h0BAD_F00D, 5, 1'b0, 1'b0);
    ready_mode = 0;

    do_txn(1'b0, 16'h2003, 32'h0, 1, 1'b1, 1'b0);
    do_txn(1'b0, 16'h2003, 32'h0, 1, 1'b0, 1'b0);
    do_txn(1'b1, 16'h4001, 32'hCAFE_F00D, 1, 1'b1, 1'b0);
    do_txn(1'b0, 16'h4001, 32'h0, 3, 1'b0, 1'b0);

    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h41);
    check("stray_idle", o_busy, 0);
    do_txn(1'b0, 16'h2000, 32'h0, 3, 1'b0, 1'b1);

    send_byte(8'h57);
    send_byte(8'h10);
    check("mid_cmd_busy", o_busy, 1);
    pulse_reset();
    do_txn(1'b0, 16'h0000, 32'h0, 1, 1'b0, 1'b0);

    no_ack = 1'b1;
    t.addr = 16'h5007; t.we = 4'h0; t.dat = 32'h0; t.wr = 1'b0; t.width = TO;
    bus_q.push_back(t);
    send_byte(8'h52);
    send_byte(8'h50);
    send_byte(8'h07);
    repeat (3) @(posedge i_clk);
    #1;
    check("bus_stb_before_reset", o_stb, 1);
    pulse_reset();
    do_txn(1'b0, 16'h0000, 32'h0, 1, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [15:0] a;
      a = {4'($urandom), 8'h00, 4'($urandom)};
      ready_mode = $urandom % 3;
      do_txn(1'($urandom), a, $urandom, $urandom_range(1, 7), ($urandom % 8 == 0), 1'($urandom));
      repeat ($urandom % 3) @(posedge i_clk);
    end

    repeat (5) @(posedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
